// File: rtl/snoop_loader_pkg.sv
// Shared opcodes, status codes and FSM state type for the snoop loader.
package snoop_loader_pkg;

  localparam logic [7:0] OP_WPRG  = 8'h01;
  localparam logic [7:0] OP_WMEM  = 8'h02;
  localparam logic [7:0] OP_RMEM  = 8'h03;
  localparam logic [7:0] OP_RUN   = 8'h04;
  localparam logic [7:0] OP_HALT  = 8'h05;

  localparam logic [7:0] ST_OK    = 8'h00;
  localparam logic [7:0] ST_BADOP = 8'hEE;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_WDATA,
    S_RISSUE,
    S_RWAIT,
    S_RCAP,
    S_RSEND,
    S_STATUS
  } stateT;

  // States in which a host byte may be taken off the rx link.
  function automatic logic acceptsRx(input stateT s);
    return (s == S_IDLE) || (s == S_ADDR) || (s == S_LEN) || (s == S_WDATA);
  endfunction

endpackage

// File: rtl/snoop_loader_if.sv
// Host byte link plus CPU snoop port; master is the loader, slave the host/core side.
interface snoop_loader_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] snoopa;
  logic [7:0] snoopd;
  logic [7:0] snoopq;
  logic       snoopm;
  logic       snoopp;
  logic       cpu_reset;
  logic       busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, snoopq,
    output rx_ready, tx_data, tx_valid, snoopa, snoopd, snoopm, snoopp, cpu_reset, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, snoopq,
    input  rx_ready, tx_data, tx_valid, snoopa, snoopd, snoopm, snoopp, cpu_reset, busy
  );

endinterface

// File: rtl/snoop_loader.sv
// Byte-command sequencer for the CPU snoop port (load, read back, run/halt).
// Optional SNOOP_LOADER_AUTOHALT_EN: a WPRG/WMEM opcode also halts the core.
module snoop_loader
  import snoop_loader_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  snoop_loader_if.master bus
);

  stateT       r_state, w_nextState;
  logic [7:0]  r_op, w_nextOp;
  logic [7:0]  r_addr, w_nextAddr;
  logic [8:0]  r_count, w_nextCount;
  logic        r_rxReady, w_nextRxReady;
  logic [7:0]  r_txData, w_nextTxData;
  logic        r_txValid, w_nextTxValid;
  logic [7:0]  r_snoopA, w_nextSnoopA;
  logic [7:0]  r_snoopD, w_nextSnoopD;
  logic        r_snoopM, w_nextSnoopM;
  logic        r_snoopP, w_nextSnoopP;
  logic        r_cpuReset, w_nextCpuReset;
  logic        r_busy, w_nextBusy;

  logic        w_rxFire;
  logic        w_txFire;

  assign w_rxFire = bus.rx_valid && r_rxReady;
  assign w_txFire = r_txValid && bus.tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op       <= 8'h00;
      r_addr     <= 8'h00;
      r_count    <= 9'd0;
      r_rxReady  <= 1'b0;
      r_txData   <= 8'h00;
      r_txValid  <= 1'b0;
      r_snoopA   <= 8'h00;
      r_snoopD   <= 8'h00;
      r_snoopM   <= 1'b0;
      r_snoopP   <= 1'b0;
      r_cpuReset <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_op       <= w_nextOp;
      r_addr     <= w_nextAddr;
      r_count    <= w_nextCount;
      r_rxReady  <= w_nextRxReady;
      r_txData   <= w_nextTxData;
      r_txValid  <= w_nextTxValid;
      r_snoopA   <= w_nextSnoopA;
      r_snoopD   <= w_nextSnoopD;
      r_snoopM   <= w_nextSnoopM;
      r_snoopP   <= w_nextSnoopP;
      r_cpuReset <= w_nextCpuReset;
      r_busy     <= w_nextBusy;
    end
  end

  // Every output is computed one cycle ahead so that all of them leave on flops.
  always_comb begin
    w_nextState    = r_state;
    w_nextOp       = r_op;
    w_nextAddr     = r_addr;
    w_nextCount    = r_count;
    w_nextTxData   = r_txData;
    w_nextTxValid  = r_txValid;
    w_nextSnoopA   = r_snoopA;
    w_nextSnoopD   = r_snoopD;
    w_nextSnoopM   = 1'b0;
    w_nextSnoopP   = 1'b0;
    w_nextCpuReset = r_cpuReset;

    case (r_state)
      S_IDLE: begin
        if (w_rxFire) begin
          w_nextOp = bus.rx_data;
          case (bus.rx_data)
            OP_WPRG, OP_WMEM: begin
              w_nextState = S_ADDR;
`ifdef SNOOP_LOADER_AUTOHALT_EN
              w_nextCpuReset = 1'b1;
`endif
            end
            OP_RMEM: w_nextState = S_ADDR;
            OP_RUN, OP_HALT: begin
              w_nextCpuReset = (bus.rx_data == OP_HALT);
              w_nextState    = S_STATUS;
              w_nextTxData   = ST_OK;
              w_nextTxValid  = 1'b1;
            end
            default: begin
              w_nextState   = S_STATUS;
              w_nextTxData  = ST_BADOP;
              w_nextTxValid = 1'b1;
            end
          endcase
        end
      end
      S_ADDR: begin
        if (w_rxFire) begin
          w_nextAddr  = bus.rx_data;
          w_nextState = S_LEN;
        end
      end
      S_LEN: begin
        if (w_rxFire) begin
          w_nextCount = (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
          w_nextState = (r_op == OP_RMEM) ? S_RISSUE : S_WDATA;
        end
      end
      S_WDATA: begin
        if (w_rxFire) begin
          w_nextSnoopA = r_addr;
          w_nextSnoopD = bus.rx_data;
          w_nextSnoopP = (r_op == OP_WPRG);
          w_nextSnoopM = (r_op != OP_WPRG);
          w_nextAddr   = r_addr + 8'd1;
          w_nextCount  = r_count - 9'd1;
          if (r_count == 9'd1) begin
            w_nextState   = S_STATUS;
            w_nextTxData  = ST_OK;
            w_nextTxValid = 1'b1;
          end
        end
      end
      S_RISSUE: begin
        w_nextSnoopA = r_addr;
        w_nextAddr   = r_addr + 8'd1;
        w_nextState  = S_RWAIT;
      end
      // The core registers snoopq from snoopa during this cycle.
      S_RWAIT: w_nextState = S_RCAP;
      S_RCAP: begin
        w_nextTxData  = bus.snoopq;
        w_nextTxValid = 1'b1;
        w_nextState   = S_RSEND;
      end
      S_RSEND: begin
        if (w_txFire) begin
          w_nextCount = r_count - 9'd1;
          if (r_count == 9'd1) begin
            w_nextState  = S_STATUS;
            w_nextTxData = ST_OK;
          end else begin
            w_nextTxValid = 1'b0;
            w_nextState   = S_RISSUE;
          end
        end
      end
      S_STATUS: begin
        if (w_txFire) begin
          w_nextTxValid = 1'b0;
          w_nextState   = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase

    w_nextRxReady = acceptsRx(w_nextState);
    w_nextBusy    = (w_nextState != S_IDLE);
  end

  assign bus.rx_ready  = r_rxReady;
  assign bus.tx_data   = r_txData;
  assign bus.tx_valid  = r_txValid;
  assign bus.snoopa    = r_snoopA;
  assign bus.snoopd    = r_snoopD;
  assign bus.snoopm    = r_snoopM;
  assign bus.snoopp    = r_snoopP;
  assign bus.cpu_reset = r_cpuReset;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_snoop_loader.sv
// Scoreboard bench for snoop_loader: expected tx bytes and snoop writes are queued
// as commands are sent and checked as the DUT produces them.
module tb_snoop_loader;
  import snoop_loader_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  snoop_loader_if bus();

  snoop_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int          checkCount = 0;
  int          errorCount = 0;
  int          lastWait   = 0;
  logic [7:0]  txExpQ[$];
  logic [17:0] wrExpQ[$];
  logic [7:0]  dataMem[256];
  logic        toggleReady   = 1'b0;
  logic        autoHaltWatch = 1'b0;
  logic        prevStalled   = 1'b0;
  logic [7:0]  prevData      = 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Core model: data memory written on snoopm, read data registered one cycle.
  always @(posedge clk) begin
    if (bus.snoopm) dataMem[bus.snoopa] <= bus.snoopd;
    bus.snoopq <= dataMem[bus.snoopa];
  end

  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready = toggleReady ? ~bus.tx_ready : 1'b1;
    end
  end

  // Output monitor sampled mid-cycle, ahead of the edge that completes a handshake.
  always @(negedge clk) begin
    if (rst) begin
      prevStalled = 1'b0;
    end else begin
      if (prevStalled) checkOutput("txStable", bus.tx_data, prevData);
      if (bus.tx_valid && bus.tx_ready) begin
        if (txExpQ.size() == 0) checkOutput("txUnexpected", bus.tx_data, 32'h100);
        else checkOutput("txByte", bus.tx_data, txExpQ.pop_front());
      end
      prevStalled = bus.tx_valid && !bus.tx_ready;
      prevData    = bus.tx_data;
      if (bus.snoopm || bus.snoopp) begin
        if (autoHaltWatch && bus.snoopp) checkOutput("autoHalt", bus.cpu_reset, 1);
        if (wrExpQ.size() == 0)
          checkOutput("wrUnexpected", {bus.snoopp, bus.snoopm, bus.snoopa, bus.snoopd}, 32'hDEAD_BEEF);
        else
          checkOutput("snoopWrite", {bus.snoopp, bus.snoopm, bus.snoopa, bus.snoopd}, wrExpQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    logic accepted;
    int   waitCycles;
    accepted   = 1'b0;
    waitCycles = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!accepted && waitCycles < 200) begin
      @(negedge clk);
      accepted = bus.rx_ready;
      @(posedge clk);
      #1;
      waitCycles++;
    end
    lastWait = waitCycles;
    checkOutput("rxAccept", accepted, 1);
  endtask

  task automatic endStimulus();
    bus.rx_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while ((txExpQ.size() != 0 || wrExpQ.size() != 0 || bus.busy) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(tag, (n < 2000), 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) dataMem[i] = 8'h00;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstRxReady", bus.rx_ready, 0);
    checkOutput("rstCpuReset", bus.cpu_reset, 1);
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstTxValid", bus.tx_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("postRstRxReady", bus.rx_ready, 1);
    checkOutput("postRstCpuReset", bus.cpu_reset, 1);
    checkOutput("postRstBusy", bus.busy, 0);
    checkOutput("postRstTxValid", bus.tx_valid, 0);

    $display("[TB] WPRG with address wrap");
    wrExpQ.push_back({2'b10, 8'hFE, 8'h11});
    wrExpQ.push_back({2'b10, 8'hFF, 8'h22});
    wrExpQ.push_back({2'b10, 8'h00, 8'h33});
    txExpQ.push_back(ST_OK);
    applyStimulus(OP_WPRG);
    applyStimulus(8'hFE);
    applyStimulus(8'h03);
    applyStimulus(8'h11);
    checkOutput("noBubble0", lastWait, 1);
    applyStimulus(8'h22);
    checkOutput("noBubble1", lastWait, 1);
    applyStimulus(8'h33);
    checkOutput("noBubble2", lastWait, 1);
    endStimulus();
    waitIdle("wprgDone");

    $display("[TB] WMEM then RMEM with stalling tx_ready");
    wrExpQ.push_back({2'b01, 8'h40, 8'hAA});
    wrExpQ.push_back({2'b01, 8'h41, 8'hBB});
    txExpQ.push_back(ST_OK);
    applyStimulus(OP_WMEM);
    applyStimulus(8'h40);
    applyStimulus(8'h02);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    endStimulus();
    waitIdle("wmemDone");
    toggleReady = 1'b1;
    txExpQ.push_back(8'hAA);
    txExpQ.push_back(8'hBB);
    txExpQ.push_back(ST_OK);
    applyStimulus(OP_RMEM);
    applyStimulus(8'h40);
    applyStimulus(8'h02);
    endStimulus();
    waitIdle("rmemDone");
    toggleReady = 1'b0;

    $display("[TB] RUN and HALT");
    txExpQ.push_back(ST_OK);
    applyStimulus(OP_RUN);
    endStimulus();
    waitIdle("runDone");
    checkOutput("cpuResetRun", bus.cpu_reset, 0);
    txExpQ.push_back(ST_OK);
    applyStimulus(OP_HALT);
    endStimulus();
    waitIdle("haltDone");
    checkOutput("cpuResetHalt", bus.cpu_reset, 1);

`ifdef SNOOP_LOADER_AUTOHALT_EN
    $display("[TB] auto-halt on program write");
    txExpQ.push_back(ST_OK);
    applyStimulus(OP_RUN);
    endStimulus();
    waitIdle("runDone2");
    checkOutput("cpuResetRun2", bus.cpu_reset, 0);
    autoHaltWatch = 1'b1;
    wrExpQ.push_back({2'b10, 8'h00, 8'h5A});
    txExpQ.push_back(ST_OK);
    applyStimulus(OP_WPRG);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h5A);
    endStimulus();
    waitIdle("autoHaltDone");
    autoHaltWatch = 1'b0;
    checkOutput("cpuResetAutoHalt", bus.cpu_reset, 1);
`endif

    $display("[TB] unknown opcode");
    txExpQ.push_back(ST_BADOP);
    applyStimulus(8'h07);
    endStimulus();
    waitIdle("badOpDone");
    checkOutput("badOpCpuReset", bus.cpu_reset, 1);
    checkOutput("badOpBusy", bus.busy, 0);
    checkOutput("badOpRxReady", bus.rx_ready, 1);
    checkOutput("badOpMem40", dataMem[8'h40], 8'hAA);

    $display("[TB] reset in the middle of a 256-byte WMEM");
    applyStimulus(OP_WMEM);
    applyStimulus(8'h10);
    applyStimulus(8'h00);
    for (int i = 0; i < 100; i++) begin
      wrExpQ.push_back({2'b01, 8'(8'h10 + i), 8'(i)});
      applyStimulus(8'(i));
    end
    endStimulus();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("partialWrites", wrExpQ.size(), 0);
    checkOutput("partialBusy", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstBusy", bus.busy, 0);
    checkOutput("midRstTxValid", bus.tx_valid, 0);
    checkOutput("midRstCpuReset", bus.cpu_reset, 1);
    checkOutput("midRstRxReady", bus.rx_ready, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("afterRstRxReady", bus.rx_ready, 1);
    checkOutput("afterRstTxValid", bus.tx_valid, 0);
    txExpQ.push_back(ST_OK);
    applyStimulus(OP_RUN);
    endStimulus();
    waitIdle("runAfterRst");
    checkOutput("cpuResetAfterRst", bus.cpu_reset, 0);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
